// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, wait-counter width, requester IDs.
// No logic of its own; latency and backpressure are defined by the users of these types.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam int WAIT_CNT_W   = 3;
  localparam int STARVE_CNT_W = 4;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants made while a fetch waits; starve is registered, valid the cycle after a grant.
// No backpressure: it only observes grant pulses and never stalls either requester.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic data_gnt,
  input  logic inst_gnt,
  input  logic inst_req,
  output logic starve
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inst_gnt) begin
      cnt_d = '0;
    end else if (data_gnt) begin
      // A data grant with no fetch waiting breaks the run.
      if (!inst_req) begin
        cnt_d = '0;
      end else if (cnt_q != STARVE_CNT_W'(LIMIT)) begin
        cnt_d = cnt_q + STARVE_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve = (cnt_q >= STARVE_CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter; transfer = 1 grant + WAIT_CYCLES+1 access + 1 resp cycle.
// Requests wait outside IDLE; data wins ties unless MEM_ARB_STARVE_GUARD_EN forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int WAIT_CYCLES  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait
    $error("mem_port_arbiter: WAIT_CYCLES must be 0..7");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
  end

  arb_state_e        state_q, state_d;
  wait_cnt_t         cnt_q, cnt_d;
  req_id_e           who_q, who_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       inst_rdata_q, inst_rdata_d;
  logic [31:0]       data_rdata_q, data_rdata_d;
  logic              starve;

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .data_gnt(data_gnt),
    .inst_gnt(inst_gnt),
    .inst_req(inst_req),
    .starve  (starve)
  );
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    who_d        = who_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_gnt     = 1'b0;
    data_gnt     = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    inst_rvalid  = 1'b0;
    data_rvalid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Reset gating keeps grants silent while reset holds the FSM in IDLE.
        data_gnt = !reset && data_req && !(starve && inst_req);
        inst_gnt = !reset && inst_req && !data_gnt;
        if (data_gnt) begin
          who_d   = REQ_DATA;
          addr_d  = data_addr;
          we_d    = data_we;
          wdata_d = data_wdata;
        end else if (inst_gnt) begin
          who_d   = REQ_INST;
          addr_d  = inst_addr;
          we_d    = 1'b0;
          wdata_d = '0;
        end
        if (data_gnt || inst_gnt) begin
          cnt_d   = wait_cnt_t'(WAIT_CYCLES);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_re = !we_q;
        if (cnt_q == '0) begin
          mem_we  = we_q;
          state_d = ST_RESP;
          // Writes leave the requester's read register untouched.
          if (!we_q) begin
            if (who_q == REQ_DATA) data_rdata_d = mem_rdata;
            else                   inst_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - wait_cnt_t'(1);
        end
      end
      ST_RESP: begin
        inst_rvalid = (who_q == REQ_INST);
        data_rvalid = (who_q == REQ_DATA);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      who_q        <= REQ_INST;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      who_q        <= who_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle, plus directed literal checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int W      = 2;
  localparam int LIM    = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req, inst_gnt, inst_rvalid;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_rdata;
  logic              data_req, data_we, data_gnt, data_rvalid;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata, data_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_we, mem_re;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (W),
    .STARVE_LIMIT(LIM)
  ) u_dut (
    .clk        (clk),
    .reset      (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_gnt   (inst_gnt),
    .inst_rvalid(inst_rvalid),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_gnt   (data_gnt),
    .data_rvalid(data_rvalid),
    .data_rdata (data_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Model: m_ph = cycles elapsed since the grant (0 = idle, 1..W+1 access, W+2 response).
  int          m_ph = 0;
  bit          m_who = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_ird = '0, m_drd = '0;
  int          m_cons = 0;

  logic        o_ig, o_dg, o_iv, o_dv, o_re, o_we;
  logic [31:0] o_ird, o_drd, o_addr, o_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit e_dg, e_ig, idle, acc, blk;
    @(negedge clk);
    o_ig = inst_gnt;  o_dg = data_gnt;  o_iv = inst_rvalid; o_dv = data_rvalid;
    o_re = mem_re;    o_we = mem_we;    o_ird = inst_rdata; o_drd = data_rdata;
    o_addr = mem_addr; o_wd = mem_wdata;
    if (rst) begin
      m_ph = 0; m_who = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_ird = '0; m_drd = '0; m_cons = 0;
    end
    idle = (m_ph == 0);
    acc  = (m_ph >= 1) && (m_ph <= W + 1);
    blk  = GUARD && (m_cons >= LIM) && inst_req;
    e_dg = !rst && idle && data_req && !blk;
    e_ig = !rst && idle && inst_req && !e_dg;
    chk("m_data_gnt",    o_dg, e_dg);
    chk("m_inst_gnt",    o_ig, e_ig);
    chk("m_mem_re",      o_re, acc && !m_we);
    chk("m_mem_we",      o_we, acc && m_we && (m_ph == W + 1));
    chk("m_inst_rvalid", o_iv, (m_ph == W + 2) && !m_who);
    chk("m_data_rvalid", o_dv, (m_ph == W + 2) && m_who);
    chk("m_inst_rdata",  o_ird, m_ird);
    chk("m_data_rdata",  o_drd, m_drd);
    chk("m_mem_addr",    o_addr, m_addr);
    chk("m_mem_wdata",   o_wd, m_wdata);
    if (!rst) begin
      if (e_dg) begin
        m_ph = 1; m_who = 1'b1; m_we = data_we; m_addr = data_addr; m_wdata = data_wdata;
        m_cons = inst_req ? m_cons + 1 : 0;
      end else if (e_ig) begin
        m_ph = 1; m_who = 1'b0; m_we = 1'b0; m_addr = inst_addr; m_wdata = '0;
        m_cons = 0;
      end else if (acc) begin
        if (m_ph == W + 1 && !m_we) begin
          if (m_who) m_drd = mem_rdata;
          else       m_ird = mem_rdata;
        end
        m_ph++;
      end else if (m_ph == W + 2) begin
        m_ph = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nwe;
    int n;
    bit seq [10];

    rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_we = 1'b0;
    data_addr = '0; data_wdata = '0; mem_rdata = '0;

    // Reset state
    cycle();
    chk("rst_gnt",   {o_ig, o_dg}, 2'b00);
    chk("rst_rv",    {o_iv, o_dv, o_re, o_we}, 4'b0000);
    chk("rst_addr",  o_addr, 32'h0);
    chk("rst_rdata", o_ird | o_drd, 32'h0);
    cycle();
    rst = 1'b0;
    cycle();

    // Lone fetch at 0x10
    inst_req = 1'b1; inst_addr = 32'h10; mem_rdata = 32'hc3e00000;
    cycle();
    chk("f_gnt", o_ig, 1'b1);
    inst_req = 1'b0;
    for (int k = 0; k < W + 1; k++) begin
      cycle();
      chk("f_re", o_re, 1'b1);
      chk("f_addr", o_addr, 32'h10);
    end
    cycle();
    chk("f_rvalid", o_iv, 1'b1);
    chk("f_rdata", o_ird, 32'hc3e00000);

    // Simultaneous requests: data write wins, fetch follows
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20; data_wdata = 32'haaaaaaaa;
    inst_req = 1'b1; inst_addr = 32'h14; mem_rdata = 32'h12345678;
    cycle();
    chk("both_dgnt", o_dg, 1'b1);
    chk("both_ignt", o_ig, 1'b0);
    data_req = 1'b0;
    nwe = 0;
    for (int k = 0; k < W + 1; k++) begin
      cycle();
      nwe += int'(o_we);
      chk("w_wdata", o_wd, 32'haaaaaaaa);
    end
    chk("w_single_we", nwe, 1);
    cycle();
    chk("w_ack", o_dv, 1'b1);
    chk("w_rdata_kept", o_drd, 32'h0);
    cycle();
    chk("then_ignt", o_ig, 1'b1);
    inst_req = 1'b0;
    repeat (W + 2) cycle();

    // Reset in the second access cycle of a write
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40; data_wdata = 32'h55551234;
    cycle();
    chk("rw_gnt", o_dg, 1'b1);
    data_req = 1'b0;
    cycle();
    chk("rw_we_early", o_we, 1'b0);
    rst = 1'b1;
    #1;
    chk("rw_out_we", {mem_we, mem_re, data_rvalid, inst_rvalid}, 4'b0000);
    chk("rw_out_addr", mem_addr, 32'h0);
    chk("rw_out_data", mem_wdata | inst_rdata | data_rdata, 32'h0);
    cycle();
    cycle();
    rst = 1'b0;
    nwe = 0;
    for (int k = 0; k < W + 3; k++) begin
      cycle();
      nwe += int'(o_we) + int'(o_dv);
    end
    chk("rw_no_pulse", nwe, 0);

    // Both held continuously: starvation behaviour
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h80; inst_req = 1'b1; inst_addr = 32'h100;
    n = 0;
    for (int c = 0; c < 10 * (W + 3); c++) begin
      mem_rdata = $urandom;
      cycle();
      if (o_dg || o_ig) begin
        if (n < 10) seq[n] = o_dg;
        n++;
      end
    end
    chk("st_count", n, 10);
    for (int k = 0; k < 10; k++)
      chk("st_seq", seq[k], GUARD ? (k % 5 != 4) : 1'b1);
    data_req = 1'b0; inst_req = 1'b0;
    repeat (W + 3) cycle();

    // Random traffic with occasional drops and resets
    for (int i = 0; i < 3000; i++) begin
      if (!inst_req || o_ig) begin
        inst_req = ($urandom_range(0, 2) != 0);
        inst_addr = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        inst_req = 1'b0;
      end
      if (!data_req || o_dg) begin
        data_req = ($urandom_range(0, 2) != 0);
        data_we = 1'($urandom_range(0, 1));
        data_addr = $urandom;
        data_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        data_req = 1'b0;
      end
      mem_rdata = $urandom;
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    repeat (W + 3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
